pair_stream_reader: RTL
=======================

// Module: pair_stream_reader
// PURPOSE
//   Read-side companion to the WTU pair memory.
//   Drives the memory's pair read port, whose combinational rd_data is {word[2a+1], word[2a]}.
//   Splits each fetched pair back into single WR_WIDTH words.
//   Streams the words out in word-address order on a valid/ready interface.
//   A transfer is a start address plus a word count.
// PARAMETERS
//   WR_WIDTH  24  width of one word; the pair bus is 2*WR_WIDTH
//   WR_DEPTH  8   words in memory (power of 2, >=2); RDA_BITWIDTH=clog2(WR_DEPTH/2), WRA_BITWIDTH=clog2(WR_DEPTH)
// PORTS
//   clk         in   1               system clock, all logic on posedge
//   rst         in   1               synchronous, active-high reset
//   start       in   1               1-cycle request; sampled only when busy==0
//   start_addr  in   WRA_BITWIDTH    first word address of the transfer
//   count       in   WRA_BITWIDTH+1  words to transfer, 0..WR_DEPTH
//   rd_addr     out  RDA_BITWIDTH    pair address to the memory = ptr[WRA_BITWIDTH-1:1]
//   rd_data     in   2*WR_WIDTH      pair from the memory; {hi,lo}, combinational
//   out_data    out  WR_WIDTH        current word
//   out_valid   out  1               out_data is valid
//   out_ready   in   1               sink accepts; handshake = out_valid & out_ready
//   busy        out  1               transfer in progress
//   done        out  1               1-cycle pulse at end of each transfer
// BEHAVIOUR
//   Reset values: out_valid=0, out_data=0, busy=0, done=0, ptr=0 (so rd_addr=0), remaining=0, pair_q=0.
//     State is IDLE.
//   Registers:
//     ptr        word pointer, WRA_BITWIDTH bits; wraps mod WR_DEPTH
//     remaining  words still to emit, WRA_BITWIDTH+1 bits
//     pair_q     captured 2*WR_WIDTH pair
//   FSM states:
//     IDLE
//       - start & count!=0: ptr<=start_addr, remaining<=count, busy<=1, go to FETCH.
//       - start & count==0: done=1 in the next cycle; stay IDLE; out_valid never asserts.
//     FETCH
//       - pair_q<=rd_data (rd_addr derived from ptr this cycle); go to EMIT.
//     EMIT
//       - out_valid=1.
//       - out_data = ptr[0] ? pair_q[2W-1:W] : pair_q[W-1:0].
//       - On handshake: ptr<=ptr+1, remaining<=remaining-1.
//         - If remaining==1: go to IDLE; busy=0 and done=1 in the next cycle.
//         - Else if the new ptr[0]==0 (pair boundary crossed): go to FETCH.
//         - Else stay in EMIT and reuse pair_q (odd half).
//   Timing and handshake:
//     - Latency: start on edge N; FETCH during cycle N+1; first out_valid in cycle N+2.
//     - Full-rate throughput (ready held high): 2 words per 3 cycles.
//     - out_valid, once high, stays high and out_data is held stable until the handshake.
//     - out_ready is ignored while out_valid==0.
//   Boundary conditions:
//     - Odd start_addr: the first word emitted is the high half of its pair.
//     - Wrap: ptr WR_DEPTH-1 -> 0.
//     - count==WR_DEPTH reads every word exactly once.
//   Simultaneous and late events:
//     - start while busy is ignored; no queueing.
//     - A memory write to a pair already captured in pair_q is not reflected.
//       Coherency is the caller's responsibility.
//   Reset mid-transfer: next cycle all outputs at reset values; the transfer is abandoned and no done is issued.
// TESTING (memory preloaded: word[i]=24'h000010+i)
//   1. start_addr=0, count=8, ready=1
//      -> out 0x10..0x17 in order.
//      -> 12 cycles from FETCH to last handshake; single done pulse.
//   2. start_addr=3, count=2
//      -> 0x13 (hi half of pair 1), then a FETCH bubble, then 0x14; rd_addr 1 then 2.
//   3. start_addr=6, count=4
//      -> 0x16, 0x17, 0x10, 0x11; rd_addr 3 then 0.
//   4. Transfer 0/4, out_ready low for 5 cycles at word 1
//      -> out_valid=1 and out_data=0x11 stable throughout; no word lost or duplicated.
//   5. count=0 -> done pulse 1 cycle after start; out_valid stays 0; busy stays 0.
//   6. Two further checks:
//      a. rst during EMIT of word 2 -> all outputs 0 next cycle; then start 5/1 -> 0x15 only.
//      b. start pulsed while busy -> ignored.

Source files
------------

// File: rtl/pair_stream_reader.sv
// Reads word pairs from a pair-wide memory port and streams the individual words
// out in word-address order over a valid/ready interface.
module pair_stream_reader #(
  parameter int WR_WIDTH = 24,
  parameter int WR_DEPTH = 8,
  localparam int WRA_BITWIDTH = $clog2(WR_DEPTH),
  localparam int RDA_BITWIDTH = $clog2(WR_DEPTH / 2)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WRA_BITWIDTH-1:0]   start_addr,
  input  logic [WRA_BITWIDTH:0]     count,
  output logic [RDA_BITWIDTH-1:0]   rd_addr,
  input  logic [2*WR_WIDTH-1:0]     rd_data,
  output logic [WR_WIDTH-1:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;

  logic [1:0]              state;
  logic [WRA_BITWIDTH-1:0] ptr;
  logic [WRA_BITWIDTH:0]   remaining;
  logic [2*WR_WIDTH-1:0]   pair_q;

  // Output handshake: a word moves when out_valid & out_ready on a rising edge;
  // out_valid and out_data hold steady until then, out_ready is don't-care otherwise.
  assign out_valid = (state == EMIT);
  assign out_data  = (state == EMIT) ? (ptr[0] ? pair_q[2*WR_WIDTH-1:WR_WIDTH]
                                               : pair_q[WR_WIDTH-1:0])
                                     : '0;
  assign busy      = (state != IDLE);
  assign rd_addr   = ptr[WRA_BITWIDTH-1:1];
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      pair_q    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              ptr       <= start_addr;
              remaining <= count;
              state     <= FETCH;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FETCH: begin
          pair_q <= rd_data;
          state  <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            ptr       <= ptr + WRA_BITWIDTH'(1);
            remaining <= remaining - (WRA_BITWIDTH+1)'(1);
            if (remaining == (WRA_BITWIDTH+1)'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end else if (ptr[0]) begin
              // Leaving the high half means the next word lives in the next pair.
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
